lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
Multi-cycle LC-3 sequencer. It sits directly upstream of the register-file stage and drives that stage's RD_LE and REG_Control strobes. It also drives the IR/PC load enables, ALU selects and a request/ready memory handshake. It decodes the latched IR and steps fetch -> decode -> execute/memory -> writeback, halting on TRAP, an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for MEM_READY; 0 disables the timeout
TIMER_W, 5, width of the wait counter; must satisfy 2^TIMER_W > MEM_TIMEOUT

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  synchronous active-low reset
IR  input  16  latched instruction register contents
NZP  input  3  current condition codes {N,Z,P}
MEM_READY  input  1  memory completes current request this cycle
IR_LE  output  1  load IR from memory data
PC_LE  output  1  load PC
PC_SEL  output  2  PC source: 0 PC+1, 1 PC+SEXT(IR[8:0]), 2 BaseR (RS1_DATA)
RD_LE  output  1  register file write enable
REG_Control  output  1  writeback source: 0 ALU result Y, 1 memory DATA
ALU_OP  output  2  0 ADD, 1 AND, 2 NOT, 3 PASS
ALU_B_IMM  output  1  ALU operand B = SEXT(IR[4:0]) when 1, RS2 when 0
CC_LE  output  1  update NZP from writeback value
MEM_REQ  output  1  memory request
MEM_WE  output  1  write qualifier for MEM_REQ
ADDR_SEL  output  1  memory address: 0 PC, 1 PC+SEXT(IR[8:0])
HALTED  output  1  sticky halt indicator
ILLEGAL  output  1  sticky; halt caused by unsupported opcode
BUS_ERR  output  1  sticky; halt caused by memory timeout

Behaviour:
- Reset: on a RESET_N=0 edge, state becomes FETCH and the wait counter clears. HALTED, ILLEGAL and BUS_ERR clear. All strobes are 0 while RESET_N=0. Reset mid-request drops MEM_REQ at once; there is no completion.
- Strobes are Mealy: decoded from state, IR, NZP and MEM_READY. Default is 0 in every state.
- FETCH:
  - Drives MEM_REQ=1, MEM_WE=0, ADDR_SEL=0.
  - With MEM_READY=1 in the same cycle: IR_LE=1, PC_LE=1, PC_SEL=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no strobes. Next state by IR[15:12]:
  - 0001 ADD, 0101 AND, 1001 NOT -> EXEC_ALU
  - 0000 BR, 1100 JMP -> EXEC_PC
  - 0010 LD -> MEM_RD
  - 0011 ST -> MEM_WR
  - 1111 TRAP -> HALT
  - any other opcode -> HALT with ILLEGAL set
- EXEC_ALU (1 cycle, then FETCH):
  - RD_LE=1, REG_Control=0, CC_LE=1.
  - ALU_OP: ADD=0, AND=1, NOT=2.
  - ALU_B_IMM=IR[5] for ADD/AND; 0 for NOT.
- EXEC_PC (1 cycle, then FETCH):
  - BR: PC_LE = |(IR[11:9] & NZP), PC_SEL=1. nzp=000 is never taken.
  - JMP: PC_LE=1, PC_SEL=2.
- MEM_RD:
  - MEM_REQ=1, MEM_WE=0, ADDR_SEL=1, held until MEM_READY.
  - On the MEM_READY cycle: RD_LE=1, REG_Control=1, CC_LE=1, next state FETCH.
- MEM_WR:
  - MEM_REQ=1, MEM_WE=1, ADDR_SEL=1, held until MEM_READY.
  - On the MEM_READY cycle: next state FETCH, no RD_LE.
- Handshake rules:
  - MEM_REQ, MEM_WE and ADDR_SEL are stable for the whole wait.
  - MEM_READY is ignored outside FETCH, MEM_RD and MEM_WR.
  - A request completes in the first cycle with MEM_READY=1, so 0-wait memory gives a 1-cycle access.
- Latency, from fetch completion to the next FETCH:
  - ALU/BR/JMP: 2 cycles.
  - LD/ST: 2 cycles plus memory wait.
- Timeout:
  - The counter clears on entry to each wait state and increments each cycle MEM_READY=0.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with MEM_READY=0, next state is HALT with BUS_ERR=1.
  - MEM_READY arriving in that same cycle wins: normal completion.
  - The counter saturates and never wraps.
- HALT: terminal until reset. HALTED=1, all strobes 0, MEM_READY ignored.

Decomposition:
- Package lc3_pkg holds:
  - opcode constants: OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_NOT, OP_JMP, OP_TRAP
  - state enum: FETCH, DECODE, EXEC_ALU, EXEC_PC, MEM_RD, MEM_WR, HALT
  - PC_SEL and ALU_OP encodings
- One sub-module: mem_wait_timer (clear, count enable, saturating TIMER_W counter, expired output).

Test Plan:
1. Reset low 2 cycles mid-MEM_RD wait, then high -> MEM_REQ=0 during reset; FETCH next cycle; HALTED=ILLEGAL=BUS_ERR=0.
2. IR=16'h1283 (ADD R1,R2,R3), 0-wait fetch -> IR_LE+PC_LE on cycle 0; cycle 2: RD_LE=1, REG_Control=0, ALU_OP=0, ALU_B_IMM=0, CC_LE=1; FETCH cycle 3.
3. IR=16'h0405 (BRz), NZP=3'b010 -> EXEC_PC PC_LE=1, PC_SEL=1. Repeat with NZP=3'b001 -> PC_LE=0.
4. IR=16'h2203 (LD R1), MEM_READY delayed 3 cycles -> MEM_REQ=1, ADDR_SEL=1 stable for 4 cycles; RD_LE=1 and REG_Control=1 only in the ready cycle.
5. IR=16'h3203 (ST), MEM_TIMEOUT=16, MEM_READY held 0 -> HALT after 16 waiting cycles; BUS_ERR=1, HALTED=1. Repeat with MEM_READY=1 on the 16th cycle -> normal completion.
6. IR=16'hD000 -> HALTED=1, ILLEGAL=1, no strobes afterwards. IR=16'hF025 -> HALTED=1, ILLEGAL=0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared opcode, state and datapath-select encodings for the LC-3 control sequencer.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC_ALU,
        EXEC_PC,
        MEM_RD,
        MEM_WR,
        HALT
    } state_t;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_REL  = 2'd1;
    localparam logic [1:0] PC_SEL_BASE = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

endpackage

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// Saturating wait counter for memory requests; expired flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMER_W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of earlier stalled cycles, so LIMIT marks the MEM_TIMEOUT-th one
    assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 sequencer: fetch, decode, execute/memory, writeback, with sticky halt causes.
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMER_W     = 5
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
    input  logic        MEM_READY,
    output logic        IR_LE,
    output logic        PC_LE,
    output logic [1:0]  PC_SEL,
    output logic        RD_LE,
    output logic        REG_Control,
    output logic [1:0]  ALU_OP,
    output logic        ALU_B_IMM,
    output logic        CC_LE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        ADDR_SEL,
    output logic        HALTED,
    output logic        ILLEGAL,
    output logic        BUS_ERR
);

    state_t     state, state_next;
    logic       illegal_q, bus_err_q;
    logic       set_illegal, set_bus_err;
    logic       timer_clr, timer_en, timer_expired;
    logic [3:0] op;

    assign op = IR[15:12];

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        timer_clr   = 1'b1;
        timer_en    = 1'b0;
        IR_LE       = 1'b0;
        PC_LE       = 1'b0;
        PC_SEL      = PC_SEL_INC;
        RD_LE       = 1'b0;
        REG_Control = 1'b0;
        ALU_OP      = ALU_ADD;
        ALU_B_IMM   = 1'b0;
        CC_LE       = 1'b0;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        ADDR_SEL    = 1'b0;

        unique case (state)
            FETCH: begin
                MEM_REQ   = 1'b1;
                timer_clr = MEM_READY;
                timer_en  = !MEM_READY;
                if (MEM_READY) begin
                    IR_LE      = 1'b1;
                    PC_LE      = 1'b1;
                    PC_SEL     = PC_SEL_INC;
                    state_next = DECODE;
                end else if (timer_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = HALT;
                end
            end

            DECODE: begin
                unique case (op)
                    OP_ADD, OP_AND, OP_NOT: state_next = EXEC_ALU;
                    OP_BR, OP_JMP:          state_next = EXEC_PC;
                    OP_LD:                  state_next = MEM_RD;
                    OP_ST:                  state_next = MEM_WR;
                    OP_TRAP:                state_next = HALT;
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = HALT;
                    end
                endcase
            end

            EXEC_ALU: begin
                RD_LE      = 1'b1;
                CC_LE      = 1'b1;
                state_next = FETCH;
                if (op == OP_NOT) begin
                    ALU_OP = ALU_NOT;
                end else begin
                    ALU_OP    = (op == OP_AND) ? ALU_AND : ALU_ADD;
                    ALU_B_IMM = IR[5];
                end
            end

            EXEC_PC: begin
                state_next = FETCH;
                if (op == OP_JMP) begin
                    PC_LE  = 1'b1;
                    PC_SEL = PC_SEL_BASE;
                end else begin
                    PC_LE  = |(IR[11:9] & NZP);
                    PC_SEL = PC_SEL_REL;
                end
            end

            MEM_RD, MEM_WR: begin
                MEM_REQ   = 1'b1;
                MEM_WE    = (state == MEM_WR);
                ADDR_SEL  = 1'b1;
                timer_clr = MEM_READY;
                timer_en  = !MEM_READY;
                if (MEM_READY) begin
                    if (state == MEM_RD) begin
                        RD_LE       = 1'b1;
                        REG_Control = 1'b1;
                        CC_LE       = 1'b1;
                    end
                    state_next = FETCH;
                end else if (timer_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = HALT;
                end
            end

            HALT: state_next = HALT;

            default: state_next = FETCH;
        endcase

        // Strobes are forced low combinationally so a reset mid-request drops MEM_REQ immediately
        if (!RESET_N) begin
            IR_LE       = 1'b0;
            PC_LE       = 1'b0;
            PC_SEL      = '0;
            RD_LE       = 1'b0;
            REG_Control = 1'b0;
            ALU_OP      = '0;
            ALU_B_IMM   = 1'b0;
            CC_LE       = 1'b0;
            MEM_REQ     = 1'b0;
            MEM_WE      = 1'b0;
            ADDR_SEL    = 1'b0;
        end
    end

    assign HALTED  = (state == HALT);
    assign ILLEGAL = illegal_q;
    assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: per-cycle expected strobe vectors queued and compared at negedge.
module tb_lc3_control_fsm;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] IR = '0;
    logic [2:0]  NZP = '0;
    logic        MEM_READY = 1'b0;
    logic        IR_LE, PC_LE, RD_LE, REG_Control, ALU_B_IMM, CC_LE;
    logic        MEM_REQ, MEM_WE, ADDR_SEL, HALTED, ILLEGAL, BUS_ERR;
    logic [1:0]  PC_SEL, ALU_OP;
    logic [15:0] obs;

    lc3_control_fsm #(
        .MEM_TIMEOUT (16),
        .TIMER_W     (5)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IR          (IR),
        .NZP         (NZP),
        .MEM_READY   (MEM_READY),
        .IR_LE       (IR_LE),
        .PC_LE       (PC_LE),
        .PC_SEL      (PC_SEL),
        .RD_LE       (RD_LE),
        .REG_Control (REG_Control),
        .ALU_OP      (ALU_OP),
        .ALU_B_IMM   (ALU_B_IMM),
        .CC_LE       (CC_LE),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .ADDR_SEL    (ADDR_SEL),
        .HALTED      (HALTED),
        .ILLEGAL     (ILLEGAL),
        .BUS_ERR     (BUS_ERR)
    );

    always #5 CLK = ~CLK;

    assign obs = {IR_LE, PC_LE, PC_SEL, RD_LE, REG_Control, ALU_OP, ALU_B_IMM,
                  CC_LE, MEM_REQ, MEM_WE, ADDR_SEL, HALTED, ILLEGAL, BUS_ERR};

    localparam logic [15:0] E_IRLE = 16'h8000, E_PCLE = 16'h4000, E_PCS2 = 16'h2000;
    localparam logic [15:0] E_PCS1 = 16'h1000, E_RDLE = 16'h0800, E_REGC = 16'h0400;
    localparam logic [15:0] E_ALU2 = 16'h0200, E_ALU1 = 16'h0100, E_BIMM = 16'h0080;
    localparam logic [15:0] E_CCLE = 16'h0040, E_MREQ = 16'h0020, E_MWE  = 16'h0010;
    localparam logic [15:0] E_ADDR = 16'h0008, E_HALT = 16'h0004, E_ILL  = 16'h0002;
    localparam logic [15:0] E_BERR = 16'h0001;
    localparam logic [15:0] FETCH_OK = E_IRLE | E_PCLE | E_MREQ;
    localparam logic [15:0] NONE     = 16'h0000;

    typedef struct {
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic step(input logic rst, input logic [15:0] ir, input logic [2:0] nzp,
                        input logic rdy, input logic [15:0] ev, input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET_N   = rst;
        IR        = ir;
        NZP       = nzp;
        MEM_READY = rdy;
        e.v   = ev;
        e.tag = tag;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) passes++;
        else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    endtask

    initial begin
        repeat (2) @(posedge CLK);

        // reset asserted in the middle of a load wait
        step(1, 16'h2203, 3'b000, 1, FETCH_OK,      "t1_fetch");
        step(1, 16'h2203, 3'b000, 0, NONE,          "t1_decode");
        step(1, 16'h2203, 3'b000, 0, E_MREQ|E_ADDR, "t1_rd_wait0");
        step(1, 16'h2203, 3'b000, 0, E_MREQ|E_ADDR, "t1_rd_wait1");
        step(0, 16'h2203, 3'b000, 0, NONE,          "t1_rst0_no_req");
        step(0, 16'h2203, 3'b000, 1, NONE,          "t1_rst1_no_req");

        // ALU ops
        step(1, 16'h1283, 3'b000, 1, FETCH_OK,              "t2_fetch_after_rst");
        step(1, 16'h1283, 3'b000, 0, NONE,                  "t2_add_decode");
        step(1, 16'h1283, 3'b000, 0, E_RDLE|E_CCLE,         "t2_add_exec");
        step(1, 16'h5262, 3'b000, 1, FETCH_OK,              "and_fetch");
        step(1, 16'h5262, 3'b000, 0, NONE,                  "and_decode");
        step(1, 16'h5262, 3'b000, 0, E_RDLE|E_CCLE|E_ALU1|E_BIMM, "and_imm_exec");
        step(1, 16'h927F, 3'b000, 1, FETCH_OK,              "not_fetch");
        step(1, 16'h927F, 3'b000, 0, NONE,                  "not_decode");
        step(1, 16'h927F, 3'b000, 0, E_RDLE|E_CCLE|E_ALU2,  "not_exec");

        // stalled fetch, then branches and jump
        step(1, 16'h0405, 3'b010, 0, E_MREQ,        "fetch_stall");
        step(1, 16'h0405, 3'b010, 1, FETCH_OK,      "brz_fetch");
        step(1, 16'h0405, 3'b010, 0, NONE,          "brz_decode");
        step(1, 16'h0405, 3'b010, 0, E_PCLE|E_PCS1, "brz_taken");
        step(1, 16'h0405, 3'b001, 1, FETCH_OK,      "brz2_fetch");
        step(1, 16'h0405, 3'b001, 0, NONE,          "brz2_decode");
        step(1, 16'h0405, 3'b001, 0, E_PCS1,        "brz_not_taken");
        step(1, 16'h0005, 3'b111, 1, FETCH_OK,      "br000_fetch");
        step(1, 16'h0005, 3'b111, 0, NONE,          "br000_decode");
        step(1, 16'h0005, 3'b111, 0, E_PCS1,        "br_nzp000_never");
        step(1, 16'hC080, 3'b000, 1, FETCH_OK,      "jmp_fetch");
        step(1, 16'hC080, 3'b000, 1, NONE,          "jmp_decode_rdy_ignored");
        step(1, 16'hC080, 3'b000, 1, E_PCLE|E_PCS2, "jmp_exec");

        // load with three wait cycles
        step(1, 16'h2203, 3'b000, 1, FETCH_OK, "ld_fetch");
        step(1, 16'h2203, 3'b000, 0, NONE,     "ld_decode");
        for (int i = 0; i < 3; i++)
            step(1, 16'h2203, 3'b000, 0, E_MREQ|E_ADDR, $sformatf("ld_wait%0d", i));
        step(1, 16'h2203, 3'b000, 1, E_MREQ|E_ADDR|E_RDLE|E_REGC|E_CCLE, "ld_done");

        // store timeout
        step(1, 16'h3203, 3'b000, 1, FETCH_OK, "st_fetch");
        step(1, 16'h3203, 3'b000, 0, NONE,     "st_decode");
        for (int i = 0; i < 16; i++)
            step(1, 16'h3203, 3'b000, 0, E_MREQ|E_MWE|E_ADDR, $sformatf("st_wait%0d", i));
        step(1, 16'h3203, 3'b000, 1, E_HALT|E_BERR, "st_timeout_halt");
        step(1, 16'h3203, 3'b000, 1, E_HALT|E_BERR, "st_halt_sticky");
        step(0, 16'h3203, 3'b000, 0, E_HALT|E_BERR, "st_rst_before_edge");
        step(0, 16'h3203, 3'b000, 0, NONE,          "st_rst_cleared");

        // store completing on the last permitted cycle
        step(1, 16'h3203, 3'b000, 1, FETCH_OK, "st2_fetch");
        step(1, 16'h3203, 3'b000, 0, NONE,     "st2_decode");
        for (int i = 0; i < 15; i++)
            step(1, 16'h3203, 3'b000, 0, E_MREQ|E_MWE|E_ADDR, $sformatf("st2_wait%0d", i));
        step(1, 16'h3203, 3'b000, 1, E_MREQ|E_MWE|E_ADDR, "st2_ready_at_limit");

        // illegal opcode, then TRAP
        step(1, 16'hD000, 3'b000, 1, FETCH_OK, "ill_fetch_after_st");
        step(1, 16'hD000, 3'b000, 0, NONE,     "ill_decode");
        for (int i = 0; i < 3; i++)
            step(1, 16'hD000, 3'b111, 1, E_HALT|E_ILL, $sformatf("ill_halt%0d", i));
        step(0, 16'hF025, 3'b000, 0, E_HALT|E_ILL, "ill_rst_before_edge");
        step(0, 16'hF025, 3'b000, 0, NONE,         "ill_rst_cleared");
        step(1, 16'hF025, 3'b000, 1, FETCH_OK,     "trap_fetch");
        step(1, 16'hF025, 3'b000, 0, NONE,         "trap_decode");
        step(1, 16'hF025, 3'b000, 1, E_HALT,       "trap_halt0");
        step(1, 16'hF025, 3'b000, 1, E_HALT,       "trap_halt1");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
